// File: rtl/run_sequencer_if.sv
// Run-control bus between the test bench / decoder side and the run sequencer.
interface run_sequencer_if #(
   parameter int unsigned PC_W  = 10,
   parameter int unsigned CNT_W = 16
);

   // launch handshake
   logic             Start;
   logic [PC_W-1:0]  StartAddr;

   // per-instruction control flags from decoder / ALU
   logic             jump_en;
   logic             branch_taken;
   logic             done_in;
   logic             mem_op;
   logic [PC_W-1:0]  Target;

   // sequencer results
   logic [PC_W-1:0]  PC;
   logic             exec_en;
   logic             Ack;
   logic             timeout;
   logic [CNT_W-1:0] cycle_count;

   modport master (
      output Start, StartAddr, jump_en, branch_taken, done_in, mem_op, Target,
      input  PC, exec_en, Ack, timeout, cycle_count
   );

   modport slave (
      input  Start, StartAddr, jump_en, branch_taken, done_in, mem_op, Target,
      output PC, exec_en, Ack, timeout, cycle_count
   );

endinterface

// File: rtl/run_sequencer.sv
// Run controller for the 9-bit accumulator core: owns the PC, the start/halt
// handshake, the commit strobe, LW/SW stretching and the cycle counter.
module run_sequencer #(
   parameter int unsigned PC_W       = 10,
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned MAX_CYCLES = 65000
) (
   input  logic          Clk,
   input  logic          Reset,
   run_sequencer_if.slave bus
);

   localparam int unsigned     WAIT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
   localparam bit              MEM_MULTI = (MEM_LAT != 0);
   localparam logic [CNT_W-1:0]  WD_LAST  = CNT_W'(MAX_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_SAT  = '1;
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [PC_W-1:0]   PC_ONE   = PC_W'(1);
   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MEM_LAT);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_RUN      = 2'd1,
      S_MEM_WAIT = 2'd2,
      S_HALT     = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [PC_W-1:0]   r_pc;
   logic [PC_W-1:0]   w_pc_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [WAIT_W-1:0] r_wait;
   logic [WAIT_W-1:0] w_wait_nxt;
   logic              r_ack;
   logic              w_ack_nxt;
   logic              r_timeout;
   logic              w_timeout_nxt;
   logic              w_exec;
   logic              w_wd_hit;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic [PC_W-1:0]   w_pc_inc;

   // saturating cycle count, sequential PC and watchdog compare
   assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_ONE;
   assign w_pc_inc  = r_pc + PC_ONE;
   assign w_wd_hit  = (r_cnt == WD_LAST);

   // state register and all registered outputs
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state   <= S_IDLE;
         r_pc      <= '0;
         r_cnt     <= '0;
         r_wait    <= '0;
         r_ack     <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pc      <= w_pc_nxt;
         r_cnt     <= w_cnt_nxt;
         r_wait    <= w_wait_nxt;
         r_ack     <= w_ack_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   // next-state, datapath updates and the commit strobe
   always_comb begin
      w_state_nxt   = r_state;
      w_pc_nxt      = r_pc;
      w_cnt_nxt     = r_cnt;
      w_wait_nxt    = r_wait;
      w_ack_nxt     = r_ack;
      w_timeout_nxt = r_timeout;
      w_exec        = 1'b0;

      case (r_state)
         S_IDLE, S_HALT: begin
            if (bus.Start) begin
               w_state_nxt   = S_RUN;
               w_pc_nxt      = bus.StartAddr;
               w_cnt_nxt     = '0;
               w_timeout_nxt = 1'b0;
               w_ack_nxt     = 1'b0;
            end
         end

         S_RUN: begin
            w_cnt_nxt = w_cnt_inc;
            if (w_wd_hit) begin
               w_state_nxt   = S_HALT;
               w_ack_nxt     = 1'b1;
               w_timeout_nxt = 1'b1;
            end else if (bus.done_in) begin
               w_state_nxt = S_HALT;
               w_ack_nxt   = 1'b1;
            end else if (bus.mem_op && MEM_MULTI) begin
               w_state_nxt = S_MEM_WAIT;
               w_wait_nxt  = WAIT_INIT;
            end else begin
               w_exec = 1'b1;
               // mem_op only reaches here with single-cycle memory and then
               // behaves like any other instruction
               if (bus.jump_en || bus.branch_taken) begin
                  w_pc_nxt = bus.Target;
               end else begin
                  w_pc_nxt = w_pc_inc;
               end
            end
         end

         S_MEM_WAIT: begin
            w_cnt_nxt = w_cnt_inc;
            if (w_wd_hit) begin
               w_state_nxt   = S_HALT;
               w_ack_nxt     = 1'b1;
               w_timeout_nxt = 1'b1;
            end else begin
               w_wait_nxt = r_wait - WAIT_ONE;
               // LW/SW always falls through to the next sequential address
               if (r_wait == WAIT_ONE) begin
                  w_exec      = 1'b1;
                  w_pc_nxt    = w_pc_inc;
                  w_state_nxt = S_RUN;
               end
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // no architectural write may commit in a reset cycle
      if (Reset) begin
         w_exec = 1'b0;
      end
   end

   assign bus.PC          = r_pc;
   assign bus.exec_en     = w_exec;
   assign bus.Ack         = r_ack;
   assign bus.timeout     = r_timeout;
   assign bus.cycle_count = r_cnt;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: instance A uses 2-cycle memory and the
// default watchdog, instance B uses single-cycle memory and a 10-cycle watchdog.
module tb_run_sequencer;

   localparam int unsigned PC_W  = 10;
   localparam int unsigned CNT_W = 16;

   logic clk;
   logic rst_a;
   logic rst_b;
   int   n_chk;
   int   n_fail;
   logic [CNT_W-1:0] exp_cnt;

   run_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) a_if ();
   run_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) b_if ();

   run_sequencer #(.PC_W(PC_W), .MEM_LAT(2), .CNT_W(CNT_W), .MAX_CYCLES(65000)) dut_a (
      .Clk   (clk),
      .Reset (rst_a),
      .bus   (a_if.slave)
   );

   run_sequencer #(.PC_W(PC_W), .MEM_LAT(0), .CNT_W(CNT_W), .MAX_CYCLES(10)) dut_b (
      .Clk   (clk),
      .Reset (rst_b),
      .bus   (b_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // drive one cycle of inputs on instance A at the falling edge
   task automatic drv_a(input logic st, input logic [PC_W-1:0] sa, input logic j,
                        input logic b, input logic d, input logic m,
                        input logic [PC_W-1:0] tgt);
      @(negedge clk);
      a_if.Start = st; a_if.StartAddr = sa; a_if.jump_en = j;
      a_if.branch_taken = b; a_if.done_in = d; a_if.mem_op = m; a_if.Target = tgt;
      #1;
   endtask

   // drive one cycle of inputs on instance B at the falling edge
   task automatic drv_b(input logic st, input logic [PC_W-1:0] sa, input logic j,
                        input logic b, input logic d, input logic m,
                        input logic [PC_W-1:0] tgt);
      @(negedge clk);
      b_if.Start = st; b_if.StartAddr = sa; b_if.jump_en = j;
      b_if.branch_taken = b; b_if.done_in = d; b_if.mem_op = m; b_if.Target = tgt;
      #1;
   endtask

   task automatic test_reset();
      rst_a = 1'b1;
      drv_a(1'b1, 10'd5, 1'b1, 1'b0, 1'b0, 1'b0, 10'd3);
      n_chk++; if (a_if.exec_en !== 1'b0) begin n_fail++; $display("FAIL reset_exec: got %0b expected 0", a_if.exec_en); end
      drv_a(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
      rst_a = 1'b0;
      n_chk++; if (a_if.PC !== 10'd0) begin n_fail++; $display("FAIL reset_pc: got %0d expected 0", a_if.PC); end
      n_chk++; if (a_if.Ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %0b expected 0", a_if.Ack); end
      n_chk++; if (a_if.timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %0b expected 0", a_if.timeout); end
      n_chk++; if (a_if.cycle_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", a_if.cycle_count); end
   endtask

   task automatic test_basic();
      drv_a(1'b1, 10'd5, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
      n_chk++; if (a_if.exec_en !== 1'b0) begin n_fail++; $display("FAIL idle_exec: got %0b expected 0", a_if.exec_en); end
      exp_cnt = '0;
      for (int i = 0; i < 3; i++) begin
         drv_a(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
         n_chk++; if (a_if.PC !== PC_W'(5 + i)) begin n_fail++; $display("FAIL basic_pc%0d: got %0d expected %0d", i, a_if.PC, 5 + i); end
         n_chk++; if (a_if.exec_en !== 1'b1) begin n_fail++; $display("FAIL basic_exec%0d: got %0b expected 1", i, a_if.exec_en); end
         exp_cnt++;
      end
      drv_a(1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd12);
      n_chk++; if (a_if.PC !== 10'd8) begin n_fail++; $display("FAIL basic_pc_end: got %0d expected 8", a_if.PC); end
      n_chk++; if (a_if.cycle_count !== 16'd3) begin n_fail++; $display("FAIL basic_count: got %0d expected 3", a_if.cycle_count); end
      exp_cnt++;
   endtask

   task automatic test_jump();
      logic            tj[7]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic            tb[7]   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [PC_W-1:0] ttgt[7] = '{10'd40, 10'd1023, 10'd0, 10'd1023, 10'd0, 10'd77, 10'd20};
      logic [PC_W-1:0] tpc[7]  = '{10'd12, 10'd40, 10'd1023, 10'd0, 10'd1023, 10'd0, 10'd77};
      for (int i = 0; i < 7; i++) begin
         drv_a(1'b0, 10'd0, tj[i], tb[i], 1'b0, 1'b0, ttgt[i]);
         n_chk++; if (a_if.PC !== tpc[i]) begin n_fail++; $display("FAIL jump_pc%0d: got %0d expected %0d", i, a_if.PC, tpc[i]); end
         n_chk++; if (a_if.exec_en !== 1'b1) begin n_fail++; $display("FAIL jump_exec%0d: got %0b expected 1", i, a_if.exec_en); end
         exp_cnt++;
      end
   endtask

   task automatic test_mem();
      drv_a(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0);
      n_chk++; if (a_if.PC !== 10'd20) begin n_fail++; $display("FAIL mem_pc0: got %0d expected 20", a_if.PC); end
      n_chk++; if (a_if.exec_en !== 1'b0) begin n_fail++; $display("FAIL mem_exec0: got %0b expected 0", a_if.exec_en); end
      n_chk++; if (a_if.cycle_count !== 16'd11) begin n_fail++; $display("FAIL mem_count0: got %0d expected 11", a_if.cycle_count); end
      exp_cnt++;
      // decoder flags during the wait are ignored
      drv_a(1'b0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd99);
      n_chk++; if (a_if.PC !== 10'd20) begin n_fail++; $display("FAIL mem_pc1: got %0d expected 20", a_if.PC); end
      n_chk++; if (a_if.exec_en !== 1'b0) begin n_fail++; $display("FAIL mem_exec1: got %0b expected 0", a_if.exec_en); end
      exp_cnt++;
      drv_a(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
      n_chk++; if (a_if.PC !== 10'd20) begin n_fail++; $display("FAIL mem_pc2: got %0d expected 20", a_if.PC); end
      n_chk++; if (a_if.exec_en !== 1'b1) begin n_fail++; $display("FAIL mem_exec2: got %0b expected 1", a_if.exec_en); end
      exp_cnt++;
      // jump together with mem_op: memory access wins, PC advances by one
      drv_a(1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 10'd500);
      n_chk++; if (a_if.PC !== 10'd21) begin n_fail++; $display("FAIL mem_pc_after: got %0d expected 21", a_if.PC); end
      n_chk++; if (a_if.cycle_count !== 16'd14) begin n_fail++; $display("FAIL mem_count_after: got %0d expected 14", a_if.cycle_count); end
      n_chk++; if (a_if.exec_en !== 1'b0) begin n_fail++; $display("FAIL memj_exec0: got %0b expected 0", a_if.exec_en); end
      exp_cnt++;
      drv_a(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
      exp_cnt++;
      drv_a(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
      n_chk++; if (a_if.exec_en !== 1'b1) begin n_fail++; $display("FAIL memj_exec2: got %0b expected 1", a_if.exec_en); end
      exp_cnt++;
      drv_a(1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd30);
      n_chk++; if (a_if.PC !== 10'd22) begin n_fail++; $display("FAIL memj_pc: got %0d expected 22", a_if.PC); end
      exp_cnt++;
   endtask

   task automatic test_done();
      drv_a(1'b0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd5);
      n_chk++; if (a_if.PC !== 10'd30) begin n_fail++; $display("FAIL done_pc: got %0d expected 30", a_if.PC); end
      n_chk++; if (a_if.exec_en !== 1'b0) begin n_fail++; $display("FAIL done_exec: got %0b expected 0", a_if.exec_en); end
      exp_cnt++;
      for (int i = 0; i < 2; i++) begin
         drv_a(1'b0, 10'd0, 1'(i), 1'b0, 1'b0, 1'b0, 10'd9);
         n_chk++; if (a_if.Ack !== 1'b1) begin n_fail++; $display("FAIL halt_ack%0d: got %0b expected 1", i, a_if.Ack); end
         n_chk++; if (a_if.PC !== 10'd30) begin n_fail++; $display("FAIL halt_pc%0d: got %0d expected 30", i, a_if.PC); end
         n_chk++; if (a_if.exec_en !== 1'b0) begin n_fail++; $display("FAIL halt_exec%0d: got %0b expected 0", i, a_if.exec_en); end
         n_chk++; if (a_if.cycle_count !== exp_cnt) begin n_fail++; $display("FAIL halt_count%0d: got %0d expected %0d", i, a_if.cycle_count, exp_cnt); end
      end
      drv_a(1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
      n_chk++; if (a_if.exec_en !== 1'b0) begin n_fail++; $display("FAIL restart_exec: got %0b expected 0", a_if.exec_en); end
      drv_a(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
      n_chk++; if (a_if.Ack !== 1'b0) begin n_fail++; $display("FAIL restart_ack: got %0b expected 0", a_if.Ack); end
      n_chk++; if (a_if.PC !== 10'd0) begin n_fail++; $display("FAIL restart_pc: got %0d expected 0", a_if.PC); end
      n_chk++; if (a_if.cycle_count !== 16'd0) begin n_fail++; $display("FAIL restart_count: got %0d expected 0", a_if.cycle_count); end
      drv_a(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
      n_chk++; if (a_if.PC !== 10'd1) begin n_fail++; $display("FAIL restart_pc1: got %0d expected 1", a_if.PC); end
      n_chk++; if (a_if.cycle_count !== 16'd1) begin n_fail++; $display("FAIL restart_count1: got %0d expected 1", a_if.cycle_count); end
   endtask

   task automatic test_reset_mem_wait();
      drv_a(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0);
      n_chk++; if (a_if.PC !== 10'd2) begin n_fail++; $display("FAIL rmw_pc: got %0d expected 2", a_if.PC); end
      drv_a(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
      // second MEM_WAIT cycle would commit, reset must suppress it
      drv_a(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
      rst_a = 1'b1;
      #1;
      n_chk++; if (a_if.exec_en !== 1'b0) begin n_fail++; $display("FAIL rmw_exec: got %0b expected 0", a_if.exec_en); end
      drv_a(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
      rst_a = 1'b0;
      #1;
      n_chk++; if (a_if.PC !== 10'd0) begin n_fail++; $display("FAIL rmw_pc0: got %0d expected 0", a_if.PC); end
      n_chk++; if (a_if.cycle_count !== 16'd0) begin n_fail++; $display("FAIL rmw_count: got %0d expected 0", a_if.cycle_count); end
      n_chk++; if (a_if.exec_en !== 1'b0) begin n_fail++; $display("FAIL rmw_idle_exec: got %0b expected 0", a_if.exec_en); end
      drv_a(1'b1, 10'd100, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
      drv_a(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
      n_chk++; if (a_if.PC !== 10'd100) begin n_fail++; $display("FAIL resume_pc: got %0d expected 100", a_if.PC); end
      n_chk++; if (a_if.exec_en !== 1'b1) begin n_fail++; $display("FAIL resume_exec: got %0b expected 1", a_if.exec_en); end
      drv_a(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0);
      // Start during MEM_WAIT and RUN is ignored
      drv_a(1'b1, 10'd7, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
      drv_a(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
      n_chk++; if (a_if.exec_en !== 1'b1) begin n_fail++; $display("FAIL resume_mem_exec: got %0b expected 1", a_if.exec_en); end
      drv_a(1'b1, 10'd7, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
      n_chk++; if (a_if.PC !== 10'd102) begin n_fail++; $display("FAIL resume_pc2: got %0d expected 102", a_if.PC); end
      drv_a(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
      n_chk++; if (a_if.PC !== 10'd103) begin n_fail++; $display("FAIL start_ignored_pc: got %0d expected 103", a_if.PC); end
   endtask

   task automatic test_watchdog();
      logic [PC_W-1:0] epc;
      logic            eex;
      drv_b(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
      rst_b = 1'b0;
      drv_b(1'b1, 10'd50, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
      for (int i = 0; i < 10; i++) begin
         // jump loop at 50, with one single-cycle LW/SW at step 3
         drv_b(1'b0, 10'd0, 1'(i != 3), 1'b0, 1'b0, 1'(i == 3), 10'd50);
         epc = (i == 4) ? 10'd51 : 10'd50;
         eex = (i < 9) ? 1'b1 : 1'b0;
         n_chk++; if (b_if.PC !== epc) begin n_fail++; $display("FAIL wd_pc%0d: got %0d expected %0d", i, b_if.PC, epc); end
         n_chk++; if (b_if.exec_en !== eex) begin n_fail++; $display("FAIL wd_exec%0d: got %0b expected %0b", i, b_if.exec_en, eex); end
         n_chk++; if (b_if.cycle_count !== CNT_W'(i)) begin n_fail++; $display("FAIL wd_count%0d: got %0d expected %0d", i, b_if.cycle_count, i); end
      end
      drv_b(1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd50);
      n_chk++; if (b_if.Ack !== 1'b1) begin n_fail++; $display("FAIL wd_ack: got %0b expected 1", b_if.Ack); end
      n_chk++; if (b_if.timeout !== 1'b1) begin n_fail++; $display("FAIL wd_timeout: got %0b expected 1", b_if.timeout); end
      n_chk++; if (b_if.cycle_count !== 16'd10) begin n_fail++; $display("FAIL wd_count_end: got %0d expected 10", b_if.cycle_count); end
      n_chk++; if (b_if.PC !== 10'd50) begin n_fail++; $display("FAIL wd_pc_end: got %0d expected 50", b_if.PC); end
      n_chk++; if (b_if.exec_en !== 1'b0) begin n_fail++; $display("FAIL wd_halt_exec: got %0b expected 0", b_if.exec_en); end
      drv_b(1'b1, 10'd3, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
      drv_b(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
      n_chk++; if (b_if.timeout !== 1'b0) begin n_fail++; $display("FAIL wd_restart_timeout: got %0b expected 0", b_if.timeout); end
      n_chk++; if (b_if.Ack !== 1'b0) begin n_fail++; $display("FAIL wd_restart_ack: got %0b expected 0", b_if.Ack); end
      n_chk++; if (b_if.PC !== 10'd3) begin n_fail++; $display("FAIL wd_restart_pc: got %0d expected 3", b_if.PC); end
      n_chk++; if (b_if.exec_en !== 1'b1) begin n_fail++; $display("FAIL wd_restart_exec: got %0b expected 1", b_if.exec_en); end
   endtask

   initial begin
      n_chk   = 0;
      n_fail  = 0;
      exp_cnt = '0;
      rst_a   = 1'b1;
      rst_b   = 1'b1;
      a_if.Start = 1'b0; a_if.StartAddr = '0; a_if.jump_en = 1'b0; a_if.branch_taken = 1'b0;
      a_if.done_in = 1'b0; a_if.mem_op = 1'b0; a_if.Target = '0;
      b_if.Start = 1'b0; b_if.StartAddr = '0; b_if.jump_en = 1'b0; b_if.branch_taken = 1'b0;
      b_if.done_in = 1'b0; b_if.mem_op = 1'b0; b_if.Target = '0;

      test_reset();
      test_basic();
      test_jump();
      test_mem();
      test_done();
      test_reset_mem_wait();
      test_watchdog();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Top-level run controller for the 9-bit accumulator core; owns the program counter and the start/halt handshake with the test bench.
- Consumes per-instruction control flags from the combinational decoder and ALU (jump_en, branch_taken, done, mem_op).
- Produces the fetch address plus a commit strobe (exec_en) that gates every architectural write: register file, accumulator, carry reg and data memory.
- Stretches LW/SW to a fixed multi-cycle data-memory latency and counts executed cycles for benchmarking.

Parameters:
- PC_W, 10, program counter / instruction ROM address width
- MEM_LAT, 2, extra wait cycles for LW/SW; 0 means single-cycle memory
- CNT_W, 16, width of the cycle counter
- MAX_CYCLES, 65000, watchdog limit; run aborts to HALT when the counter reaches it

Ports:
- Clk  input  1  system clock
- Reset  input  1  synchronous, active-high reset
- Start  input  1  level/pulse; launches a run from IDLE or HALT
- StartAddr  input  PC_W  PC loaded when a run launches
- jump_en  input  1  decoder: unconditional jump
- branch_taken  input  1  ALU/decoder: conditional branch resolved taken
- done_in  input  1  decoder: DONE instruction
- mem_op  input  1  decoder: current instruction is LW or SW
- Target  input  PC_W  jump/branch destination address
- PC  output  PC_W  instruction fetch address
- exec_en  output  1  commit strobe for the current instruction
- Ack  output  1  run finished (HALT state)
- timeout  output  1  run ended by watchdog
- cycle_count  output  CNT_W  cycles spent in RUN plus MEM_WAIT

Behaviour:
- Reset, checked first every edge and valid in any state including mid-run or mid-MEM_WAIT:
  - state=IDLE, PC=0, Ack=0, timeout=0, cycle_count=0, wait_cnt=0.
  - exec_en=0 in the same cycle Reset is high.
- State IDLE:
  - exec_en=0.
  - If Start: PC<=StartAddr, cycle_count<=0, timeout<=0, go to RUN.
- State RUN (one instruction per cycle; cycle_count increments each cycle, saturating at all-ones). Priority order:
  1. done_in: exec_en=0, PC held, go to HALT. DONE takes 1 cycle and commits nothing.
  2. mem_op with MEM_LAT>0: exec_en=0, PC held, wait_cnt<=MEM_LAT, go to MEM_WAIT.
  3. Otherwise exec_en=1. If jump_en or branch_taken: PC<=Target. Else PC<=PC+1, wrapping modulo 2^PC_W.
- mem_op with MEM_LAT=0 commits like a normal instruction, following rule 3.
- State MEM_WAIT:
  - cycle_count increments; wait_cnt decrements each cycle.
  - When wait_cnt==1: exec_en=1, PC<=PC+1, go to RUN. LW/SW therefore total MEM_LAT+1 cycles with exactly one commit in the last cycle.
  - Otherwise exec_en=0.
  - Decoder inputs are ignored except mem_op, which is not re-sampled.
- Watchdog: in RUN or MEM_WAIT, if cycle_count==MAX_CYCLES-1 at a clock edge, go to HALT with timeout<=1. This outranks every RUN/MEM_WAIT transition and suppresses exec_en in that cycle.
- State HALT:
  - Ack=1, exec_en=0; PC and cycle_count frozen.
  - If Start: Ack<=0, timeout<=0, PC<=StartAddr, cycle_count<=0, go to RUN.
- Start while in RUN or MEM_WAIT is ignored.
- Simultaneous jump_en and branch_taken both select Target.
- jump_en/branch_taken with mem_op: mem_op wins and PC advances by 1.
- exec_en is combinational from state and inputs; all other outputs are registered.

Test Plan:
- Reset, then Start=1 for 1 cycle with StartAddr=5; three plain ALU instructions -> PC sequence 5,6,7,8; exec_en=1 for 3 cycles; cycle_count=3.
- At PC=12, jump_en=1, Target=40 -> next PC=40. Repeat with branch_taken=1, Target=0 at PC=1023 -> PC=0. Plain instruction at PC=1023 -> PC wraps to 0.
- mem_op=1 at PC=20 with MEM_LAT=2 -> PC stays 20 for 3 cycles, exec_en pattern 0,0,1, then PC=21; cycle_count advances by 3.
- done_in=1 at PC=30 -> next cycle Ack=1, PC=30, exec_en=0, cycle_count frozen. Start=1 with StartAddr=0 -> Ack=0, PC=0, cycle_count restarts from 0.
- MAX_CYCLES=10 with an infinite jump loop -> after 10 run cycles Ack=1, timeout=1, no further commits.
- Reset asserted on the second cycle of MEM_WAIT -> next cycle state IDLE, PC=0, exec_en=0; Start without Reset resumes normally.
